// File: rtl/nn_dense_layer.sv
// nn_dense_layer: fully connected layer with one shared MAC, signed Q-format.
// Macro NN_RELU_EN selects ReLU activation; undefined gives identity.
package ap_parameters;
    localparam int NN_DATA_WIDTH  = 16;
    localparam int NN_ARRAY_WIDTH = 26;
endpackage

module nn_dense_layer
    import ap_parameters::*;
#(
    parameter int NEURONS    = 8,
    parameter int FRAC_BITS  = 8,
    parameter int ACC_WIDTH  = 40,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start,
    input  logic [NN_ARRAY_WIDTH-1:0][NN_DATA_WIDTH-1:0] data_in,
    output logic [ADDR_WIDTH-1:0]                        weight_addr,
    input  logic signed [NN_DATA_WIDTH-1:0]              weight_data,
    output logic                                         busy,
    output logic                                         done,
    output logic [NEURONS-1:0][NN_DATA_WIDTH-1:0]        data_out
);

    localparam int DW     = NN_DATA_WIDTH;
    localparam int AW     = NN_ARRAY_WIDTH;
    localparam int STRIDE = AW + 1;
    localparam int PW     = 2 * DW;
    localparam int JW     = $clog2(AW + 2);
    localparam int NW     = (NEURONS > 1) ? $clog2(NEURONS) : 1;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        ACC_WIDTH'((64'sd1 <<< (DW - 1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, MAC, BIAS, DONE} state_t;

    state_t state, state_nxt;

    logic [AW-1:0][DW-1:0]       x_q;
    logic signed [ACC_WIDTH-1:0] acc;
    logic [NW-1:0]               n;
    logic [JW-1:0]               j;
    logic [ADDR_WIDTH-1:0]       base;
    logic [NEURONS-1:0][DW-1:0]  staging;
    logic [NEURONS-1:0][DW-1:0]  staging_nxt;

    logic [DW-1:0]               xsel;
    logic signed [PW-1:0]        prod;
    logic signed [ACC_WIDTH-1:0] bias_ext;
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [ACC_WIDTH-1:0] shifted;
    logic [DW-1:0]               sat;
    logic [DW-1:0]               act;

    assign busy = (state == MAC) || (state == BIAS);
    assign done = (state == DONE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and weight address; address only driven while in MAC
    always_comb begin
        state_nxt   = state;
        weight_addr = '0;
        case (state)
            IDLE: if (start) state_nxt = MAC;
            MAC: begin
                weight_addr = base + ADDR_WIDTH'(j);
                if (j == JW'(AW)) state_nxt = BIAS;
            end
            BIAS: state_nxt = (n == NW'(NEURONS - 1)) ? DONE : MAC;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Product of the input paired with the word returned for the previous address
    always_comb begin
        xsel     = (j == '0) ? '0 : x_q[j - JW'(1)];
        prod     = PW'($signed(xsel)) * PW'(weight_data);
        bias_ext = ACC_WIDTH'(weight_data) <<< FRAC_BITS;
        sum      = acc + bias_ext;
        shifted  = sum >>> FRAC_BITS;
    end

    // Saturate to the data width, then apply the activation
    always_comb begin
        if (shifted > SAT_MAX)      sat = {1'b0, {(DW-1){1'b1}}};
        else if (shifted < SAT_MIN) sat = {1'b1, {(DW-1){1'b0}}};
        else                        sat = shifted[DW-1:0];
`ifdef NN_RELU_EN
        act = sat[DW-1] ? '0 : sat;
`else
        act = sat;
`endif
    end

    // Staging with the current neuron's result merged in during BIAS
    always_comb begin
        staging_nxt = staging;
        if (state == BIAS) staging_nxt[n] = act;
    end

    // Datapath: capture, accumulate, bias/write-back, neuron sequencing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q      <= '0;
            acc      <= '0;
            n        <= '0;
            j        <= '0;
            base     <= '0;
            staging  <= '0;
            data_out <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    x_q  <= data_in;
                    acc  <= '0;
                    n    <= '0;
                    j    <= '0;
                    base <= '0;
                end
                MAC: begin
                    if (j != '0) acc <= acc + ACC_WIDTH'(prod);
                    j <= j + JW'(1);
                end
                BIAS: begin
                    acc     <= '0;
                    j       <= '0;
                    staging <= staging_nxt;
                    if (state_nxt == MAC) begin
                        n    <= n + NW'(1);
                        base <= base + ADDR_WIDTH'(STRIDE);
                    end else begin
                        data_out <= staging_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_dense_layer.sv
// tb_nn_dense_layer: directed frames against a synchronous weight memory model.
// Expected results follow NN_RELU_EN when defined.
module tb_nn_dense_layer;
    import ap_parameters::*;

    localparam int NEU    = 8;
    localparam int STRIDE = NN_ARRAY_WIDTH + 1;

    logic clk;
    logic rst;
    logic start;
    logic [NN_ARRAY_WIDTH-1:0][NN_DATA_WIDTH-1:0] data_in;
    logic [7:0] weight_addr;
    logic signed [15:0] weight_data;
    logic busy;
    logic done;
    logic [NEU-1:0][15:0] data_out;

    logic [15:0] mem [0:255];
    logic [15:0] exp_out [NEU];
    int total = 0;
    int bad = 0;

    nn_dense_layer #(
        .NEURONS(NEU),
        .FRAC_BITS(8),
        .ACC_WIDTH(40),
        .ADDR_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .data_in(data_in),
        .weight_addr(weight_addr),
        .weight_data(weight_data),
        .busy(busy),
        .done(done),
        .data_out(data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word appears one cycle after its address
    always @(posedge clk) weight_data <= mem[weight_addr];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [15:0] w, input logic [15:0] b);
        for (int k = 0; k < 256; k++) mem[k] = 16'h0000;
        for (int n = 0; n < NEU; n++) begin
            for (int j = 0; j < NN_ARRAY_WIDTH; j++) mem[n*STRIDE+j] = w;
            mem[n*STRIDE+NN_ARRAY_WIDTH] = b;
        end
    endtask

    task automatic set_inputs(input logic [15:0] v);
        for (int j = 0; j < NN_ARRAY_WIDTH; j++) data_in[j] = v;
    endtask

    task automatic set_exp(input logic [15:0] v);
        for (int n = 0; n < NEU; n++) exp_out[n] = v;
    endtask

    task automatic check_outs(input string tag);
        for (int n = 0; n < NEU; n++)
            check($sformatf("%s[%0d]", tag, n), 32'(data_out[n]),
                  32'(exp_out[n]));
    endtask

    // Called at a negedge; start is raised for the accept edge that follows
    task automatic run_frame(input int pulse_at, input bit hold,
                             input int rst_at);
        int done_cnt, done_cyc, busy_err, addr_err;
        int f, pos, exp_addr, last;
        bit exp_busy, chk_addr;
        done_cnt = 0;
        done_cyc = -1;
        busy_err = 0;
        addr_err = 0;
        last = hold ? 230 : 240;
        start = 1'b1;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            start = (rst_at == 0) && (hold || c == pulse_at || c == 225);
            if (c == 1 && !hold)
                for (int j = 0; j < NN_ARRAY_WIDTH; j++)
                    data_in[j] = 16'($urandom);
            if (c == rst_at) begin
                rst = 1'b1;
                #1;
                check("rst_busy", 32'(busy), 0);
                check("rst_done", 32'(done), 0);
                check("rst_addr", 32'(weight_addr), 0);
                check("rst_dout_any", 32'(|data_out), 0);
            end
            if (rst_at != 0 && c == rst_at + 1) rst = 1'b0;
            if (rst_at != 0 && c >= rst_at) begin
                exp_busy = 1'b0;
                chk_addr = 1'b1;
                exp_addr = 0;
            end else begin
                f = (hold && c >= 227) ? c - 226 : c;
                exp_busy = (f >= 1) && (f <= 224);
                pos = (f - 1) % 28;
                chk_addr = !exp_busy || pos <= 26;
                exp_addr = exp_busy ? ((f - 1) / 28) * STRIDE + pos : 0;
            end
            if (busy !== exp_busy) busy_err++;
            if (chk_addr && weight_addr !== 8'(exp_addr)) addr_err++;
            if (done !== 1'b0) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
        end
        if (rst_at == 0) begin
            check("done_cycle", 32'(done_cyc), 225);
            check("done_count", 32'(done_cnt), 1);
        end else begin
            check("done_after_rst", 32'(done_cnt), 0);
        end
        check("busy_cycles_bad", 32'(busy_err), 0);
        check("addr_seq_bad", 32'(addr_err), 0);
        if (hold) begin
            start = 1'b0;
            done_cyc = -1;
            for (int c = last + 1; c <= 480; c++) begin
                @(negedge clk);
                if (done === 1'b1 && done_cyc < 0) done_cyc = c;
            end
            check("done_cycle_held_start", 32'(done_cyc), 451);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        data_in = '0;
        load(16'h0000, 16'h0000);
        #1;
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_addr", 32'(weight_addr), 0);
        check("reset_dout_any", 32'(|data_out), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Zero weights, bias 1.0, random inputs; start re-pulsed mid-frame
        for (int j = 0; j < NN_ARRAY_WIDTH; j++) data_in[j] = 16'($urandom);
        load(16'h0000, 16'h0100);
        run_frame(50, 1'b0, 0);
        set_exp(16'h0100);
        check_outs("bias_only");

        // Outputs hold while inputs wander and no start arrives
        for (int j = 0; j < NN_ARRAY_WIDTH; j++) data_in[j] = 16'($urandom);
        repeat (20) @(negedge clk);
        check_outs("bias_hold");

        // 26 x 1.0 x 1.0 with start held high through done
        set_inputs(16'h0100);
        load(16'h0100, 16'h0000);
        run_frame(0, 1'b1, 0);
        set_exp(16'h1A00);
        check_outs("sum_26");

        // Negative sum
        set_inputs(16'h0100);
        load(16'hFF00, 16'h0000);
        run_frame(0, 1'b0, 0);
`ifdef NN_RELU_EN
        set_exp(16'h0000);
`else
        set_exp(16'hE600);
`endif
        check_outs("neg_sum");

        // Positive saturation
        set_inputs(16'h7FFF);
        load(16'h7FFF, 16'h0000);
        run_frame(0, 1'b0, 0);
        set_exp(16'h7FFF);
        check_outs("pos_sat");

        // Reset at cycle 100 aborts the frame with no done
        set_inputs(16'h0100);
        load(16'h0100, 16'h0000);
        run_frame(0, 1'b0, 100);
        set_exp(16'h0000);
        check_outs("after_abort");

        // Fresh frame: neuron n picks input n, bias n.0
        for (int j = 0; j < NN_ARRAY_WIDTH; j++) data_in[j] = 16'((j + 1) * 16);
        load(16'h0000, 16'h0000);
        for (int n = 0; n < NEU; n++) begin
            mem[n*STRIDE+n] = 16'h0100;
            mem[n*STRIDE+NN_ARRAY_WIDTH] = 16'(n * 256);
            exp_out[n] = 16'(n * 256 + (n + 1) * 16);
        end
        run_frame(0, 1'b0, 0);
        check_outs("per_neuron");

        // Negative saturation
        set_inputs(16'h7FFF);
        load(16'h8000, 16'h0000);
        run_frame(0, 1'b0, 0);
`ifdef NN_RELU_EN
        set_exp(16'h0000);
`else
        set_exp(16'h8000);
`endif
        check_outs("neg_sat");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
